// File: rtl/cache_tile_walk_pkg.sv
// Shared types and helpers for the cache tile walker: FSM state, set-address width
// derivation and the raster next-index step used by both tile and plane counters.
package cache_tile_walk_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } walk_state_e;

  typedef struct packed {
    int x;
    int y;
  } idx_pair_t;

  function automatic int set_width(input int aw, input int lg);
    return aw - lg;
  endfunction

  // Raster step: wrap x to zero and bump y once x reaches its last index.
  function automatic idx_pair_t next_index(input int x, input int y, input int last);
    idx_pair_t nxt;
    if (x == last) begin
      nxt.x = 0;
      nxt.y = y + 1;
    end else begin
      nxt.x = x + 1;
      nxt.y = y;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cache_tile_overlap.sv
// Combinational overlap test between one cache-line tile (in a possibly subsampled
// plane) and that plane's reference block; a zero width or height never hits.
module cache_tile_overlap #(
  parameter int X_AW    = 12,
  parameter int Y_AW    = 12,
  parameter int LW_LOG2 = 3,
  parameter int LH_LOG2 = 2,
  parameter int DIM_W   = 7,
  parameter int SUB_X   = 0,
  parameter int SUB_Y   = 0
) (
  input  logic [X_AW-LW_LOG2-1:0] i_set_x,
  input  logic [Y_AW-LH_LOG2-1:0] i_set_y,
  input  logic [X_AW-1:0]         i_plane_x,
  input  logic [Y_AW-1:0]         i_plane_y,
  input  logic [DIM_W-1:0]        i_plane_w,
  input  logic [DIM_W-1:0]        i_plane_h,
  output logic                    o_hit
);

  localparam int SHX = LW_LOG2 - SUB_X;
  localparam int SHY = LH_LOG2 - SUB_Y;
  localparam int XE  = X_AW + 1;
  localparam int YE  = Y_AW + 1;

  // One extra bit keeps block ends near the top of the address space from wrapping.
  logic [XE-1:0] w_x0, w_x1, w_px0, w_px1;
  logic [YE-1:0] w_y0, w_y1, w_py0, w_py1;
  logic          w_hit_x, w_hit_y;

  assign w_x0  = XE'(i_set_x) << SHX;
  assign w_x1  = w_x0 + XE'((1 << SHX) - 1);
  assign w_px0 = XE'(i_plane_x);
  assign w_px1 = w_px0 + XE'(i_plane_w) - XE'(1);

  assign w_y0  = YE'(i_set_y) << SHY;
  assign w_y1  = w_y0 + YE'((1 << SHY) - 1);
  assign w_py0 = YE'(i_plane_y);
  assign w_py1 = w_py0 + YE'(i_plane_h) - YE'(1);

  assign w_hit_x = (i_plane_w != '0) && (w_x0 <= w_px1) && (w_px0 <= w_x1);
  assign w_hit_y = (i_plane_h != '0) && (w_y0 <= w_py1) && (w_py0 <= w_y1);
  assign o_hit   = w_hit_x & w_hit_y;

endmodule

// File: rtl/cache_tile_walker.sv
// Raster walk of a reference-block request over the cache-line tile grid, one tile per
// cycle on a valid/ready link. Optional CACHE_TILE_WALK_STATS_EN adds request/tile counters.
module cache_tile_walker
  import cache_tile_walk_pkg::*;
#(
  parameter int                    X_AW        = 12,
  parameter int                    Y_AW        = 12,
  parameter int                    LW_LOG2     = 3,
  parameter int                    LH_LOG2     = 2,
  parameter int                    DW          = 3,
  parameter int                    NUM_PLANES  = 2,
  parameter int                    DIM_W       = 7,
  parameter logic [NUM_PLANES-1:0] PLANE_SUB_X = 2'b10,
  parameter logic [NUM_PLANES-1:0] PLANE_SUB_Y = 2'b10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_is_read,
  input  logic [X_AW-1:0]               req_start_x,
  input  logic [Y_AW-1:0]               req_start_y,
  input  logic [DW-1:0]                 req_delta_x,
  input  logic [DW-1:0]                 req_delta_y,
  input  logic [NUM_PLANES*X_AW-1:0]    req_plane_x,
  input  logic [NUM_PLANES*Y_AW-1:0]    req_plane_y,
  input  logic [NUM_PLANES*DIM_W-1:0]   req_plane_w,
  input  logic [NUM_PLANES*DIM_W-1:0]   req_plane_h,
  input  logic [NUM_PLANES*DW-1:0]      req_plane_dx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_is_read,
  output logic [X_AW-LW_LOG2-1:0]       out_set_x,
  output logic [Y_AW-LH_LOG2-1:0]       out_set_y,
  output logic [DW-1:0]                 out_tile_x,
  output logic [DW-1:0]                 out_tile_y,
  output logic                          out_last,
  output logic [NUM_PLANES-1:0]         out_plane_hit,
  output logic [NUM_PLANES*DW-1:0]      out_plane_ix,
  output logic [NUM_PLANES*DW-1:0]      out_plane_iy
`ifdef CACHE_TILE_WALK_STATS_EN
  ,
  output logic [31:0]                   stat_reqs,
  output logic [31:0]                   stat_tiles
`endif
);

  localparam int SXW = set_width(X_AW, LW_LOG2);
  localparam int SYW = set_width(Y_AW, LH_LOG2);

  walk_state_e           r_state, w_state_next;
  logic                  r_is_read;
  logic [SXW-1:0]        r_base_x;
  logic [SYW-1:0]        r_base_y;
  logic [DW-1:0]         r_dx, r_dy, r_tile_x, r_tile_y;
  logic [X_AW-1:0]       r_plane_x  [NUM_PLANES];
  logic [Y_AW-1:0]       r_plane_y  [NUM_PLANES];
  logic [DIM_W-1:0]      r_plane_w  [NUM_PLANES];
  logic [DIM_W-1:0]      r_plane_h  [NUM_PLANES];
  logic [DW-1:0]         r_plane_dx [NUM_PLANES];
  logic [DW-1:0]         r_pix      [NUM_PLANES];
  logic [DW-1:0]         r_piy      [NUM_PLANES];

  logic                  w_fire, w_accept;
  logic [NUM_PLANES-1:0] w_hit;
  idx_pair_t             w_tile_next;
  idx_pair_t             w_plane_next [NUM_PLANES];

  assign out_valid   = (r_state == ACTIVE);
  assign out_is_read = r_is_read;
  assign out_tile_x  = r_tile_x;
  assign out_tile_y  = r_tile_y;
  assign out_set_x   = SXW'(r_tile_x) + r_base_x;
  assign out_set_y   = SYW'(r_tile_y) + r_base_y;
  assign out_last    = out_valid && (r_tile_x == r_dx) && (r_tile_y == r_dy);
  assign out_plane_hit = w_hit;

  assign w_fire      = out_valid & out_ready;
  assign w_accept    = req_valid & req_ready;
  assign w_tile_next = next_index(int'(r_tile_x), int'(r_tile_y), int'(r_dx));

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    cache_tile_overlap #(
      .X_AW    (X_AW),
      .Y_AW    (Y_AW),
      .LW_LOG2 (LW_LOG2),
      .LH_LOG2 (LH_LOG2),
      .DIM_W   (DIM_W),
      .SUB_X   (PLANE_SUB_X[p] ? 1 : 0),
      .SUB_Y   (PLANE_SUB_Y[p] ? 1 : 0)
    ) u_overlap (
      .i_set_x   (out_set_x),
      .i_set_y   (out_set_y),
      .i_plane_x (r_plane_x[p]),
      .i_plane_y (r_plane_y[p]),
      .i_plane_w (r_plane_w[p]),
      .i_plane_h (r_plane_h[p]),
      .o_hit     (w_hit[p])
    );

    assign w_plane_next[p] = next_index(int'(r_pix[p]), int'(r_piy[p]), int'(r_plane_dx[p]));
    assign out_plane_ix[p*DW +: DW] = r_pix[p];
    assign out_plane_iy[p*DW +: DW] = r_piy[p];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // The final handshake reopens the request port so a waiting request starts without a bubble.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (w_fire && out_last) begin
          req_ready = 1'b1;
          if (!req_valid) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_read <= 1'b0;
      r_base_x  <= '0;
      r_base_y  <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_tile_x  <= '0;
      r_tile_y  <= '0;
      for (int p = 0; p < NUM_PLANES; p++) begin
        r_plane_x[p]  <= '0;
        r_plane_y[p]  <= '0;
        r_plane_w[p]  <= '0;
        r_plane_h[p]  <= '0;
        r_plane_dx[p] <= '0;
        r_pix[p]      <= '0;
        r_piy[p]      <= '0;
      end
    end else if (w_accept) begin
      r_is_read <= req_is_read;
      r_base_x  <= SXW'(req_start_x >> LW_LOG2);
      r_base_y  <= SYW'(req_start_y >> LH_LOG2);
      r_dx      <= req_delta_x;
      r_dy      <= req_delta_y;
      r_tile_x  <= '0;
      r_tile_y  <= '0;
      for (int p = 0; p < NUM_PLANES; p++) begin
        r_plane_x[p]  <= req_plane_x[p*X_AW +: X_AW];
        r_plane_y[p]  <= req_plane_y[p*Y_AW +: Y_AW];
        r_plane_w[p]  <= req_plane_w[p*DIM_W +: DIM_W];
        r_plane_h[p]  <= req_plane_h[p*DIM_W +: DIM_W];
        r_plane_dx[p] <= req_plane_dx[p*DW +: DW];
        r_pix[p]      <= '0;
        r_piy[p]      <= '0;
      end
    end else if (w_fire) begin
      r_tile_x <= DW'(w_tile_next.x);
      r_tile_y <= DW'(w_tile_next.y);
      for (int p = 0; p < NUM_PLANES; p++) begin
        if (w_hit[p]) begin
          r_pix[p] <= DW'(w_plane_next[p].x);
          r_piy[p] <= DW'(w_plane_next[p].y);
        end
      end
    end
  end

`ifdef CACHE_TILE_WALK_STATS_EN
  logic [31:0] r_stat_reqs, r_stat_tiles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_reqs  <= '0;
      r_stat_tiles <= '0;
    end else begin
      if (w_accept && (r_stat_reqs != '1))  r_stat_reqs  <= r_stat_reqs + 32'd1;
      if (w_fire && (r_stat_tiles != '1))   r_stat_tiles <= r_stat_tiles + 32'd1;
    end
  end

  assign stat_reqs  = r_stat_reqs;
  assign stat_tiles = r_stat_tiles;
`endif

endmodule

// File: tb/tb_cache_tile_walker.sv
// Directed self-checking bench for cache_tile_walker: raster order, stalls, back-to-back
// requests, plane hit tracking, set-address wrap and reset in mid-walk.
module tb_cache_tile_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_read;
  logic [11:0] req_start_x, req_start_y;
  logic [2:0]  req_delta_x, req_delta_y;
  logic [23:0] req_plane_x, req_plane_y;
  logic [13:0] req_plane_w, req_plane_h;
  logic [5:0]  req_plane_dx;
  logic        out_valid, out_ready, out_is_read, out_last;
  logic [8:0]  out_set_x;
  logic [9:0]  out_set_y;
  logic [2:0]  out_tile_x, out_tile_y;
  logic [1:0]  out_plane_hit;
  logic [5:0]  out_plane_ix, out_plane_iy;
`ifdef CACHE_TILE_WALK_STATS_EN
  logic [31:0] stat_reqs, stat_tiles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_tile_walker dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_read   (req_is_read),
    .req_start_x   (req_start_x),
    .req_start_y   (req_start_y),
    .req_delta_x   (req_delta_x),
    .req_delta_y   (req_delta_y),
    .req_plane_x   (req_plane_x),
    .req_plane_y   (req_plane_y),
    .req_plane_w   (req_plane_w),
    .req_plane_h   (req_plane_h),
    .req_plane_dx  (req_plane_dx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_is_read   (out_is_read),
    .out_set_x     (out_set_x),
    .out_set_y     (out_set_y),
    .out_tile_x    (out_tile_x),
    .out_tile_y    (out_tile_y),
    .out_last      (out_last),
    .out_plane_hit (out_plane_hit),
    .out_plane_ix  (out_plane_ix),
    .out_plane_iy  (out_plane_iy)
`ifdef CACHE_TILE_WALK_STATS_EN
    ,
    .stat_reqs     (stat_reqs),
    .stat_tiles    (stat_tiles)
`endif
  );

  task automatic set_req(input logic [11:0] sx, input logic [11:0] sy,
                         input logic [2:0] dx, input logic [2:0] dy, input logic rd);
    req_start_x  = sx;
    req_start_y  = sy;
    req_delta_x  = dx;
    req_delta_y  = dy;
    req_is_read  = rd;
    req_plane_x  = '0;
    req_plane_y  = '0;
    req_plane_w  = '0;
    req_plane_h  = '0;
    req_plane_dx = '0;
  endtask

  task automatic test_reset();
    logic [38:0] got;
    reset     = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    set_req(12'h0, 12'h0, 3'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid_last got=%b%b exp=00", out_valid, out_last);
    end
    got = {out_is_read, out_set_x, out_set_y, out_tile_x, out_tile_y, out_plane_hit, out_plane_ix, out_plane_iy};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", got);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_grid();
    logic [27:0] got, exp;
    @(negedge clk);
    set_req(12'h040, 12'h010, 3'd1, 3'd2, 1'b1);
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL grid_req_ready got=%b exp=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_set_y, out_last, out_is_read};
      exp = {1'b1, 3'(k % 2), 3'(k / 2), 9'(8 + k % 2), 10'(4 + k / 2), (k == 5), 1'b1};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL grid_beat%0d got=%h exp=%h", k, got, exp);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL grid_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, req_ready);
    end
  endtask

  task automatic test_stall();
    logic [24:0] got, exp;
    int k = 0;
    int s = 0;
    @(negedge clk);
    set_req(12'h040, 12'h010, 3'd1, 3'd2, 1'b0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 12 && k < 6; cyc++) begin
      #1;
      got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_set_y, out_last};
      exp = {1'b1, 3'(k % 2), 3'(k / 2), 9'(8 + k % 2), 10'(4 + k / 2), (k == 5)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL stall_cyc%0d got=%h exp=%h", cyc, got, exp);
      end
      if (k == 1 && s < 3) begin
        out_ready = 1'b0;
        s++;
      end else begin
        out_ready = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_idle got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] got, exp;
    @(negedge clk);
    set_req(12'h000, 12'h000, 3'd1, 3'd0, 1'b1);
    req_valid = 1'b1;
    @(negedge clk);
    set_req(12'h080, 12'h008, 3'd0, 3'd1, 1'b0);
    req_valid = 1'b1;
    #1;
    got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_is_read, out_last, req_ready, 6'd0};
    exp = {1'b1, 3'd0, 3'd0, 9'd0, 1'b1, 1'b0, 1'b0, 6'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_a0 got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1;
    got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_is_read, out_last, req_ready, 6'd0};
    exp = {1'b1, 3'd1, 3'd0, 9'd1, 1'b1, 1'b1, 1'b1, 6'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_a1 got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_set_y, out_is_read, out_last, 1'b0};
    exp = {1'b1, 3'd0, 3'd0, 9'd16, 10'd2, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_b0 got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1;
    got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_set_y, out_is_read, out_last, 1'b0};
    exp = {1'b1, 3'd0, 3'd1, 9'd16, 10'd3, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_b1 got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_idle got=%b exp=0", out_valid);
    end
  endtask

  // Chroma block covers tile column 0 on every row; luma block covers only tile (1,1).
  task automatic test_chroma();
    logic [13:0] got, exp;
    @(negedge clk);
    set_req(12'h040, 12'h010, 3'd1, 3'd2, 1'b1);
    req_plane_x  = {12'd32, 12'd72};
    req_plane_y  = {12'd8, 12'd20};
    req_plane_w  = {7'd4, 7'd8};
    req_plane_h  = {7'd6, 7'd4};
    req_plane_dx = {3'd0, 3'd0};
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      got = {out_plane_hit, out_plane_ix, out_plane_iy};
      exp = {(k % 2 == 0), (k == 3), 6'd0,
             3'((k % 2 == 0) ? k / 2 : k / 2 + 1), 3'((k > 3) ? 1 : 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL chroma_beat%0d got=%h exp=%h", k, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] got, exp;
    @(negedge clk);
    set_req(12'hFF8, 12'h000, 3'd1, 3'd0, 1'b0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      got = {out_valid, out_set_x, out_last};
      exp = {1'b1, (k == 0) ? 9'h1FF : 9'h000, (k == 1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL wrap_beat%0d got=%h exp=%h", k, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] got, exp;
    @(negedge clk);
    set_req(12'h040, 12'h010, 3'd1, 3'd2, 1'b1);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_tile_x !== 3'd0 || out_tile_y !== 3'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_third got=%0d,%0d v=%b exp=0,1 v=1", out_tile_x, out_tile_y, out_valid);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    got = {out_valid, out_last, req_ready, out_tile_x, out_tile_y, out_set_x, 6'd0};
    exp = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 9'd0, 6'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL rstmid_cleared got=%h exp=%h", got, exp);
    end
    reset = 1'b0;
    set_req(12'h020, 12'h004, 3'd0, 3'd0, 1'b0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    got = {out_valid, out_tile_x, out_tile_y, out_set_x, out_set_y[5:0], out_last, 2'd0};
    exp = {1'b1, 3'd0, 3'd0, 9'd4, 6'd1, 1'b1, 2'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL rstmid_next got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_idle got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_grid();
    test_stall();
    test_back_to_back();
    test_chroma();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
